// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction memory controller.
package imem_pkg;

   typedef enum logic {CLEAR, READY} state_t;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 16;

   function automatic int unsigned bytes_of(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/imem_bank.sv
// Plain DEPTH x DATA_W storage: one registered read port, one byte-enabled write port.
module imem_bank
   import imem_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned IDX_W  = 4
)(
   input  logic                        clk,
   input  logic                        i_rd_en,
   input  logic [IDX_W-1:0]            i_rd_addr,
   output logic [DATA_W-1:0]           o_rd_data,
   input  logic                        i_wr_en,
   input  logic [IDX_W-1:0]            i_wr_addr,
   input  logic [bytes_of(DATA_W)-1:0] i_wr_be,
   input  logic [DATA_W-1:0]           i_wr_data
);

   localparam int unsigned BE_W = bytes_of(DATA_W);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_rd_en) begin
         o_rd_data <= r_mem[i_rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < BE_W; k++) begin
         if (i_wr_en && i_wr_be[k]) begin
            r_mem[i_wr_addr][8*k +: 8] <= i_wr_data[8*k +: 8];
         end
      end
   end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction memory front end: clear sequencer, load-over-fetch arbitration,
// range checks and the fetch response registers around imem_bank.
module imem_ctrl
   import imem_pkg::*;
#(
   parameter int unsigned DATA_W         = DEF_DATA_W,
   parameter int unsigned ADDR_W         = DEF_ADDR_W,
   parameter int unsigned DEPTH          = 65536,
   parameter bit          CLEAR_ON_RESET = 1'b1
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        fetch_req,
   input  logic [ADDR_W-1:0]           fetch_addr,
   output logic                        fetch_gnt,
   output logic                        fetch_valid,
   output logic [DATA_W-1:0]           fetch_data,
   output logic                        fetch_err,
   input  logic                        load_req,
   input  logic [ADDR_W-1:0]           load_addr,
   input  logic [bytes_of(DATA_W)-1:0] load_be,
   input  logic [DATA_W-1:0]           load_data,
   output logic                        load_gnt,
   output logic                        busy
);

   localparam int unsigned BE_W  = bytes_of(DATA_W);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef logic [ADDR_W:0]  ext_addr_t;
   typedef logic [IDX_W-1:0] idx_t;

   localparam ext_addr_t DEPTH_L  = ext_addr_t'(DEPTH);
   localparam idx_t      LAST_PTR = idx_t'(DEPTH - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   idx_t              r_clr_ptr;
   idx_t              w_clr_ptr_nxt;
   logic              w_clr_we;
   logic              w_ready;
   logic              w_fetch_oor;
   logic              w_load_oor;
   logic              w_bk_we;
   idx_t              w_bk_waddr;
   logic [BE_W-1:0]   w_bk_be;
   logic [DATA_W-1:0] w_bk_wdata;
   logic [DATA_W-1:0] w_rd_data;
   logic              r_valid;
   logic              r_err;
   logic              r_zero;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= CLEAR;
         r_clr_ptr <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_ptr <= w_clr_ptr_nxt;
      end
   end

   // Clear walks the array one word per cycle; without clearing it is a single idle cycle.
   always_comb begin
      w_state_nxt   = r_state;
      w_clr_ptr_nxt = r_clr_ptr;
      w_clr_we      = 1'b0;
      case (r_state)
         CLEAR: begin
            if (CLEAR_ON_RESET) begin
               w_clr_we      = ~rst;
               w_clr_ptr_nxt = r_clr_ptr + idx_t'(1);
               if (r_clr_ptr == LAST_PTR) begin
                  w_state_nxt = READY;
               end
            end else begin
               w_state_nxt = READY;
            end
         end
         READY:   w_state_nxt = READY;
         default: w_state_nxt = CLEAR;
      endcase
   end

   assign w_ready     = (r_state == READY);
   assign load_gnt    = w_ready & load_req;
   assign fetch_gnt   = w_ready & fetch_req & ~load_req;
   assign w_fetch_oor = ({1'b0, fetch_addr} >= DEPTH_L);
   assign w_load_oor  = ({1'b0, load_addr} >= DEPTH_L);
   assign busy        = ~w_ready;

   // Single write port shared between the clear sequencer and the loader.
   always_comb begin
      w_bk_we    = load_gnt & ~w_load_oor;
      w_bk_waddr = idx_t'(load_addr);
      w_bk_be    = load_be;
      w_bk_wdata = load_data;
      if (!w_ready) begin
         w_bk_we    = w_clr_we;
         w_bk_waddr = r_clr_ptr;
         w_bk_be    = '1;
         w_bk_wdata = '0;
      end
   end

   imem_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_bank (
      .clk       (clk),
      .i_rd_en   (fetch_gnt & ~w_fetch_oor),
      .i_rd_addr (idx_t'(fetch_addr)),
      .o_rd_data (w_rd_data),
      .i_wr_en   (w_bk_we),
      .i_wr_addr (w_bk_waddr),
      .i_wr_be   (w_bk_be),
      .i_wr_data (w_bk_wdata)
   );

   // r_zero masks the bank output after reset and for out-of-range fetches.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_zero  <= 1'b1;
      end else begin
         r_valid <= fetch_gnt;
         if (fetch_gnt) begin
            r_err  <= w_fetch_oor;
            r_zero <= w_fetch_oor;
         end
      end
   end

   assign fetch_valid = r_valid;
   assign fetch_err   = r_err;
   assign fetch_data  = r_zero ? '0 : w_rd_data;

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl at DEPTH=16 with hand-computed expectations.
module tb_imem_ctrl;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DEPTH  = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_gnt;
   logic              fetch_valid;
   logic [DATA_W-1:0] fetch_data;
   logic              fetch_err;
   logic              load_req;
   logic [ADDR_W-1:0] load_addr;
   logic [3:0]        load_be;
   logic [DATA_W-1:0] load_data;
   logic              load_gnt;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;

   imem_ctrl #(
      .DATA_W         (DATA_W),
      .ADDR_W         (ADDR_W),
      .DEPTH          (DEPTH),
      .CLEAR_ON_RESET (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_gnt   (fetch_gnt),
      .fetch_valid (fetch_valid),
      .fetch_data  (fetch_data),
      .fetch_err   (fetch_err),
      .load_req    (load_req),
      .load_addr   (load_addr),
      .load_be     (load_be),
      .load_data   (load_data),
      .load_gnt    (load_gnt),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
      load_req  = 1'b1;
      load_addr = a;
      load_data = d;
      load_be   = be;
      #1;
      check("load_gnt", 64'(load_gnt), 64'd1);
      tick();
      load_req = 1'b0;
   endtask

   task automatic do_fetch(input logic [ADDR_W-1:0] a, input logic [31:0] exp_d,
                           input logic exp_e, input string tag);
      fetch_req  = 1'b1;
      fetch_addr = a;
      #1;
      check({tag, "_gnt"}, 64'(fetch_gnt), 64'd1);
      tick();
      fetch_req = 1'b0;
      check({tag, "_valid"}, 64'(fetch_valid), 64'd1);
      check({tag, "_data"}, 64'(fetch_data), 64'(exp_d));
      check({tag, "_err"}, 64'(fetch_err), 64'(exp_e));
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_ready_timeout"}, 64'(busy), 64'd0);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int cnt;
      rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
      load_req = 1'b0; load_addr = '0; load_be = '0; load_data = '0;
      tick();
      tick();
      // Reset state
      check("rst_busy", 64'(busy), 64'd1);
      check("rst_valid", 64'(fetch_valid), 64'd0);
      check("rst_err", 64'(fetch_err), 64'd0);
      check("rst_data", 64'(fetch_data), 64'd0);
      check("rst_gnts", 64'({fetch_gnt, load_gnt}), 64'd0);
      rst = 1'b0;
      wait_ready("init");

      // Preload all ones, then a one-cycle reset must wipe them over 16 busy cycles
      for (int i = 0; i < 16; i++) do_load(ADDR_W'(i), 32'hFFFF_FFFF, 4'hF);
      do_fetch(16'd9, 32'hFFFF_FFFF, 1'b0, "preload");
      pulse_rst();
      fetch_req = 1'b1; fetch_addr = 16'd2;
      load_req = 1'b1; load_addr = 16'd2; load_be = 4'h0;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("clr_busy%0d", i), 64'(busy), 64'd1);
         check($sformatf("clr_gnts%0d", i), 64'({fetch_gnt, load_gnt}), 64'd0);
         tick();
      end
      check("clr_done", 64'(busy), 64'd0);
      fetch_req = 1'b0; load_req = 1'b0;
      for (int i = 0; i < 16; i++) do_fetch(ADDR_W'(i), 32'h0, 1'b0, $sformatf("clr_rd%0d", i));

      // Byte-enabled load into a cleared word
      do_load(16'd3, 32'hAABB_CCDD, 4'b0101);
      tick();
      check("be_idle_valid", 64'(fetch_valid), 64'd0);
      do_fetch(16'd3, 32'h00BB_00DD, 1'b0, "be");
      check("hold_valid_low", 64'(fetch_valid), 64'd1);
      tick();
      check("hold_valid", 64'(fetch_valid), 64'd0);
      check("hold_data", 64'(fetch_data), 64'h00BB_00DD);

      // Contention: two loads stall the fetch, which then sees the last write
      fetch_req = 1'b1; fetch_addr = 16'd5;
      load_req = 1'b1; load_addr = 16'd5; load_be = 4'hF; load_data = 32'h1234_5678;
      #1;
      check("cont0_fgnt", 64'(fetch_gnt), 64'd0);
      check("cont0_lgnt", 64'(load_gnt), 64'd1);
      tick();
      load_data = 32'h9ABC_DEF0;
      #1;
      check("cont1_fgnt", 64'(fetch_gnt), 64'd0);
      check("cont1_valid", 64'(fetch_valid), 64'd0);
      tick();
      load_req = 1'b0;
      check("cont2_valid", 64'(fetch_valid), 64'd0);
      do_fetch(16'd5, 32'h9ABC_DEF0, 1'b0, "cont");

      // Out of range: fetch errors, load is granted but does not alias onto word 4
      do_load(16'd4, 32'h4444_4444, 4'hF);
      do_fetch(16'd20, 32'h0, 1'b1, "oor");
      do_load(16'd20, 32'hDEAD_BEEF, 4'hF);
      do_fetch(16'd4, 32'h4444_4444, 1'b0, "oor_w4");

      // Reset at clear cycle 7 restarts a full 16-cycle clear
      pulse_rst();
      for (int i = 0; i < 7; i++) tick();
      check("mid_busy", 64'(busy), 64'd1);
      pulse_rst();
      cnt = 0;
      while (busy && cnt < 100) begin
         tick();
         cnt++;
      end
      check("mid_clear_len", 64'(cnt), 64'd16);
      do_fetch(16'd5, 32'h0, 1'b0, "mid_rd5");

      // Streaming: 8 back-to-back fetches
      for (int i = 0; i < 8; i++) do_load(ADDR_W'(i), 32'h1000_0000 + 32'(i) * 32'h11, 4'hF);
      fetch_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         fetch_addr = ADDR_W'(i);
         tick();
         check($sformatf("strm_valid%0d", i), 64'(fetch_valid), 64'd1);
         check($sformatf("strm_data%0d", i), 64'(fetch_data), 64'(32'h1000_0000 + 32'(i) * 32'h11));
      end
      fetch_req = 1'b0;
      tick();
      check("strm_end", 64'(fetch_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
